// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler sharing one SPI transmitter among NUM_REQ requesters.
// Holds each granted word on DATA for exactly one SS_N-delimited frame.
module spi_tx_scheduler #(
   parameter int                     NUM_REQ     = 4,
   parameter int                     DATA_LENGTH = 8,
   parameter logic [DATA_LENGTH-1:0] IDLE_WORD   = '0,
   parameter int                     TIMEOUT     = 4095
) (
   input  logic                             SCLK,
   input  logic                             RST,
   input  logic [NUM_REQ-1:0]               REQ_VALID,
   input  logic [NUM_REQ*DATA_LENGTH-1:0]   REQ_DATA,
   output logic [NUM_REQ-1:0]               REQ_READY,
   input  logic                             SS_N,
   input  logic                             ERR_CLR,
   output logic [DATA_LENGTH-1:0]           DATA,
   output logic                             BUSY,
   output logic [$clog2(NUM_REQ)-1:0]       GRANT_ID,
   output logic                             FRAME_DONE,
   output logic                             TIMEOUT_ERR
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int WCW = $clog2(TIMEOUT+1);

   typedef enum logic [1:0] {IDLE, WAIT_START, ACTIVE} state_t;

   state_t                              state;
   logic                                ss_q;
   logic [IDW-1:0]                      ptr;
   logic [WCW-1:0]                      wcnt;
   logic [NUM_REQ-1:0][DATA_LENGTH-1:0] req_word;
   logic [IDW-1:0]                      winner;
   logic                                found;
   logic [IDW-1:0]                      ptr_nxt;
   logic                                fall, rise, wait_expired;

   assign req_word     = REQ_DATA;
   assign fall         = ss_q && !SS_N;
   assign rise         = !ss_q && SS_N;
   assign wait_expired = (wcnt == WCW'(TIMEOUT-1));
   assign ptr_nxt      = (GRANT_ID == IDW'(NUM_REQ-1)) ? '0 : GRANT_ID + 1'b1;

   // Scan downward so the last hit is the first valid requester at or after ptr.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         int idx;
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (REQ_VALID[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   always_comb begin
      REQ_READY = '0;
      if (state == IDLE && found) REQ_READY[winner] = 1'b1;
   end

   always_ff @(posedge SCLK) begin
      if (RST) begin
         state       <= IDLE;
         ss_q        <= 1'b1;
         ptr         <= '0;
         wcnt        <= '0;
         DATA        <= IDLE_WORD;
         BUSY        <= 1'b0;
         GRANT_ID    <= '0;
         FRAME_DONE  <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         ss_q       <= SS_N;
         FRAME_DONE <= 1'b0;
         if (ERR_CLR) TIMEOUT_ERR <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  DATA     <= req_word[winner];
                  GRANT_ID <= winner;
                  BUSY     <= 1'b1;
                  wcnt     <= '0;
                  state    <= WAIT_START;
               end
            end
            // A frame already running at grant time shows no fall, so it is skipped.
            WAIT_START: begin
               if (fall) begin
                  wcnt  <= '0;
                  state <= ACTIVE;
               end else if (wait_expired) begin
                  TIMEOUT_ERR <= 1'b1;
                  DATA        <= IDLE_WORD;
                  BUSY        <= 1'b0;
                  ptr         <= ptr_nxt;
                  state       <= IDLE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            ACTIVE: begin
               if (rise) begin
                  FRAME_DONE <= 1'b1;
                  DATA       <= IDLE_WORD;
                  BUSY       <= 1'b0;
                  ptr        <= ptr_nxt;
                  state      <= IDLE;
               end else if (wait_expired) begin
                  TIMEOUT_ERR <= 1'b1;
                  DATA        <= IDLE_WORD;
                  BUSY        <= 1'b0;
                  ptr         <= ptr_nxt;
                  state       <= IDLE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_tx_scheduler.md
# spi_tx_scheduler

Round-robin frame scheduler that shares the single SPI transmitter among NUM_REQ requesters. It accepts one word per grant over a valid/ready handshake and holds that word on the transmitter's parallel DATA input for exactly one complete frame. A frame is delimited by the transmitter's SS_N falling and rising edges, after which the next requester is served. The block runs in the SCLK domain, the same domain in which the transmitter registers SS_N.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- DATA_LENGTH, 8, word width; matches the transmitter frame length
- IDLE_WORD, 8'h00, word driven on DATA when no frame is owned
- TIMEOUT, 4095, max SCLK cycles spent waiting on one frame (≥1)

Ports:
- SCLK  in  1  clock; all logic on posedge
- RST  in  1  reset, synchronous, active-high
- REQ_VALID  in  NUM_REQ  per-requester word available
- REQ_DATA  in  NUM_REQ*DATA_LENGTH  requester i word in bits [i*DATA_LENGTH +: DATA_LENGTH]
- REQ_READY  out  NUM_REQ  one-hot acceptance; transfer on an edge where VALID[i]&&READY[i]
- SS_N  in  1  slave-select from the transmitter
- ERR_CLR  in  1  clears TIMEOUT_ERR
- DATA  out  DATA_LENGTH  word to the transmitter
- BUSY  out  1  a granted word owns DATA
- GRANT_ID  out  $clog2(NUM_REQ)  index of the current or last owner
- FRAME_DONE  out  1  one-cycle pulse when the owned frame completes
- TIMEOUT_ERR  out  1  sticky; a frame wait exceeded TIMEOUT

## Operation
- Internal state: `ss_q` (SS_N delayed one cycle, reset 1), round-robin pointer `ptr` (reset 0), wait counter `wcnt` of width $clog2(TIMEOUT+1).
- Edge detects:
  - fall = ss_q && !SS_N
  - rise = !ss_q && SS_N
- FSM states: IDLE, WAIT_START, ACTIVE.
- IDLE:
  - Winner is the first i with REQ_VALID[i], searching ptr, ptr+1, … mod NUM_REQ.
  - REQ_READY is combinational: one-hot at the winner, asserted only in IDLE, all zeros otherwise.
  - On the accepting edge: DATA <= REQ_DATA[winner], GRANT_ID <= winner, BUSY <= 1, wcnt <= 0, go to WAIT_START.
- WAIT_START:
  - Waits for a fall. A frame already in progress at grant time is never counted.
  - On fall: go to ACTIVE, wcnt <= 0. Otherwise wcnt++.
- ACTIVE:
  - On rise: FRAME_DONE <= 1 for one cycle, DATA <= IDLE_WORD, BUSY <= 0, ptr <= (GRANT_ID+1) mod NUM_REQ, go to IDLE.
  - Otherwise wcnt++.
- Timeout:
  - Applies in WAIT_START or ACTIVE when wcnt == TIMEOUT-1 and the exit edge is absent.
  - Sets TIMEOUT_ERR, drops the frame without a FRAME_DONE pulse, DATA <= IDLE_WORD, BUSY <= 0, ptr advances as on completion, go to IDLE.
- Exit edge and timeout in the same cycle: the edge wins.
- TIMEOUT_ERR is cleared by ERR_CLR. Set and ERR_CLR in the same cycle: set wins.
- DATA is constant from the cycle after acceptance until completion or timeout. Changes in REQ_VALID or REQ_DATA after acceptance have no effect.
- Pointer wrap: ptr after GRANT_ID = NUM_REQ-1 is 0.

## Timing
- Reset values: DATA=IDLE_WORD, REQ_READY=0, BUSY=0, GRANT_ID=0, FRAME_DONE=0, TIMEOUT_ERR=0; FSM=IDLE, ptr=0, wcnt=0, ss_q=1.
- RST asserted mid-frame aborts to the reset state at the next edge. No FRAME_DONE pulse and no error are produced.
- Acceptance latency is 0 cycles: REQ_READY is valid in the same cycle VALID is seen in IDLE.
- DATA and BUSY update 1 cycle after acceptance.
- FRAME_DONE rises 1 cycle after the SCLK edge on which SS_N is first sampled high following the ACTIVE fall.
- REQ_READY is low for the cycle after FRAME_DONE's edge only in the sense that IDLE is re-entered. Back-to-back grants are possible: the next acceptance can occur in the first IDLE cycle.
- Throughput: one word per transmitter frame plus 1 IDLE cycle.

## Test plan
- Single request: REQ_VALID[2]=1 with word 8'hA5 while SS_N=1 -> READY[2] pulses for 1 cycle; DATA=8'hA5, BUSY=1 next cycle; after SS_N 1→0→1, FRAME_DONE pulses once, DATA=8'h00, GRANT_ID=2, ptr=3.
- Round robin: all four VALID held high, ptr=0 -> grants in order 0,1,2,3,0, each lasting exactly one full frame; no requester starved.
- Grant mid-frame: accept while SS_N=0 -> that rise is ignored; FRAME_DONE only after the next fall followed by a rise; DATA is stable throughout.
- Timeout: TIMEOUT=16, SS_N held 1 after grant -> TIMEOUT_ERR=1 after 16 cycles in WAIT_START; no FRAME_DONE; BUSY=0; ptr advanced. ERR_CLR asserted in the same cycle as a new timeout -> TIMEOUT_ERR stays 1.
- Reset mid-frame: RST pulsed in ACTIVE -> next cycle all outputs at reset values; a subsequent SS_N rise produces no FRAME_DONE.
- Wrap and edge-vs-timeout tie: grant to requester 3 gives ptr=0; SS_N rise on the cycle wcnt==TIMEOUT-1 -> FRAME_DONE=1 and TIMEOUT_ERR stays 0.
